// File: rtl/acc32_ctrl.sv
// acc32_ctrl: handshake-driven 32-bit accumulator around a ripple-carry adder (rca32).
// ADD/SUB hold the adder operands for SETTLE_CYC cycles before the sum is committed.

module rca32 (
    output logic [31:0] s,
    output logic        co,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci
);
    logic w_c;

    // Carry is rippled procedurally so the chain stays a single combinational cone.
    always_comb begin
        s   = '0;
        w_c = ci;
        for (int i = 0; i < 32; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end
endmodule

module acc32_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] d,
    output logic [31:0] acc,
    output logic        co,
    output logic        ovf,
    output logic        done
);
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("acc32_ctrl: SETTLE_CYC must be in 1..15");
    end

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_op;
    logic [31:0] r_d;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc;
    logic        r_co, r_ovf;

    logic        w_accept, w_sub, w_rca_co, w_ovf;
    logic [31:0] w_b, w_s;

    assign w_accept = in_valid && in_ready;
    assign w_sub    = (r_op == OP_SUB);
    assign w_b      = w_sub ? ~r_d : r_d;
    assign w_ovf    = (r_acc[31] == w_b[31]) && (w_s[31] != r_acc[31]);

    // Operands come only from registers, so they are stable through EXEC and WB.
    rca32 u_rca (
        .s  (w_s),
        .co (w_rca_co),
        .a  (r_acc),
        .b  (w_b),
        .ci (w_sub)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = (op == OP_ADD || op == OP_SUB) ? S_EXEC : S_WB;
            end
            S_EXEC: if (r_cnt == 4'd0) w_next = S_WB;
            S_WB: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= OP_LOAD;
            r_d   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_d   <= d;
                r_cnt <= CNT_INIT;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (r_state == S_WB) begin
                case (r_op)
                    OP_LOAD: r_acc <= r_d;
                    OP_CLEAR: begin
                        r_acc <= '0;
                        r_co  <= 1'b0;
                        r_ovf <= 1'b0;
                    end
                    default: begin
                        r_acc <= w_s;
                        r_co  <= w_rca_co;
                        r_ovf <= w_ovf;
                    end
                endcase
            end
        end
    end

    assign acc = r_acc;
    assign co  = r_co;
    assign ovf = r_ovf;
endmodule

// File: tb/tb_acc32_ctrl.sv
// Directed bench for acc32_ctrl (SETTLE_CYC=2): hand-computed results, latencies and handshake behaviour.
module tb_acc32_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] d;
    logic [31:0] acc;
    logic        co, ovf, done;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

    acc32_ctrl #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .d(d), .acc(acc), .co(co), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, checks accept-to-done latency and the committed state.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v, input int lat,
                          input logic [31:0] e_acc, input logic e_co, input logic e_ovf);
        int n, w;
        in_valid = 1'b1; op = o; d = v;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        tick();
        chk({tag, "_acc"}, acc, e_acc);
        chk({tag, "_co"},  32'(co),  32'(e_co));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, "_done_lo"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nacc, ndone, nbusy, cyc;
        rst = 1'b1; in_valid = 1'b0; op = LOAD; d = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_acc", acc, 32'h0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        run_op("ld5",   LOAD, 32'h0000_0005, 1, 32'h0000_0005, 1'b0, 1'b0);
        run_op("add3",  ADD,  32'h0000_0003, 3, 32'h0000_0008, 1'b0, 1'b0);
        run_op("ldF",   LOAD, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("wrap",  ADD,  32'h0000_0001, 3, 32'h0000_0000, 1'b1, 1'b0);
        run_op("ld7F",  LOAD, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_op("povf",  ADD,  32'h0000_0001, 3, 32'h8000_0000, 1'b0, 1'b1);
        run_op("clr1",  CLR,  32'hDEAD_BEEF, 1, 32'h0000_0000, 1'b0, 1'b0);
        run_op("ld3",   LOAD, 32'h0000_0003, 1, 32'h0000_0003, 1'b0, 1'b0);
        run_op("sub5",  SUB,  32'h0000_0005, 3, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("ld80",  LOAD, 32'h8000_0000, 1, 32'h8000_0000, 1'b0, 1'b0);
        run_op("novf",  SUB,  32'h0000_0001, 3, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("ldX",   LOAD, 32'h1234_5678, 1, 32'h1234_5678, 1'b1, 1'b1);

        // Reset in the middle of an ADD: no writeback, no done.
        in_valid = 1'b1; op = ADD; d = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("mid_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_done0", 32'(done), 32'd0);
        tick();
        chk("mid_done1", 32'(done), 32'd0);
        rst = 1'b0;
        chk("mid_acc", acc, 32'h0);
        chk("mid_co", 32'(co), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("mid_nodone", 32'(ndone), 32'd0);
        chk("mid_acc_hold", acc, 32'h0);

        // Back-to-back ADD 1 with in_valid held high.
        in_valid = 1'b1; op = ADD; d = 32'h1;
        nacc = 0; ndone = 0; nbusy = 0; cyc = 0;
        while (ndone < 4 && cyc < 40) begin
            if (done) begin
                ndone++;
                chk("b2b_wb_notready", 32'(in_ready), 32'd0);
            end
            if (!in_ready) nbusy++;
            if (in_valid && in_ready) nacc++;
            tick();
            cyc++;
            if (nacc == 4) in_valid = 1'b0;
        end
        chk("b2b_done", 32'(ndone), 32'd4);
        chk("b2b_accepts", 32'(nacc), 32'd4);
        chk("b2b_busy", 32'(nbusy), 32'd12);
        chk("b2b_acc", acc, 32'h4);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("b2b_nodup", 32'(ndone), 32'd0);
        chk("b2b_acc_hold", acc, 32'h4);
        run_op("clr2", CLR, 32'h0, 1, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
